// File: rtl/bird_sprite_renderer.sv
// Bird sprite renderer: a two-stage pixel pipeline that tests each pixel against
// the bird's bounding box, fetches the sprite bit from an external ROM and flags
// frames in which an opaque bird pixel overlaps an obstacle pixel.
module bird_sprite_renderer #(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 13,
    parameter int COORD_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] bird_x,
    input  logic [COORD_W-1:0] bird_y,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               obstacle_px,
    output logic [7:0]         rom_ad,
    input  logic               rom_dout,
    output logic               out_valid,
    output logic               out_bird,
    output logic               out_obstacle,
    output logic               frame_collision
);

    // Box extents are compared one bit wider than the screen so that a bird
    // parked near the right/bottom edge clips instead of wrapping to column 0.
    localparam logic [COORD_W:0] SW_EXT = (COORD_W+1)'(SPRITE_W);
    localparam logic [COORD_W:0] SH_EXT = (COORD_W+1)'(SPRITE_H);

    // Latched bird position (valid for the whole frame)
    logic [COORD_W-1:0] bx_q, by_q;

    // Stage 1 registers
    logic       in_box_q;
    logic       valid1_q;
    logic       obs1_q;
    logic [7:0] rom_ad_q;

    // Stage 2 (output) registers
    logic out_valid_q;
    logic out_bird_q;
    logic out_obstacle_q;

    // Collision tracking
    logic collision_live_q;
    logic frame_collision_q;

    // Stage 1 next-state values
    logic               in_box_d;
    logic [7:0]         rom_ad_d;
    logic [COORD_W:0]   px_ext, py_ext, bx_ext, by_ext, bx_end, by_end;
    logic [COORD_W-1:0] dx, dy;
    logic [15:0]        addr_full;
    logic               collision_set;

    // Bounding-box test and sprite address for the incoming pixel
    always_comb begin
        px_ext    = {1'b0, pix_x};
        py_ext    = {1'b0, pix_y};
        bx_ext    = {1'b0, bx_q};
        by_ext    = {1'b0, by_q};
        bx_end    = bx_ext + SW_EXT;
        by_end    = by_ext + SH_EXT;
        in_box_d  = pix_valid
                  & (px_ext >= bx_ext) & (px_ext < bx_end)
                  & (py_ext >= by_ext) & (py_ext < by_end);
        dx        = pix_x - bx_q;
        dy        = pix_y - by_q;
        // Only the low 8 address bits matter, so operand truncation is harmless.
        addr_full = 16'(dy) * 16'(SPRITE_W) + 16'(dx);
        rom_ad_d  = in_box_d ? addr_full[7:0] : 8'd0;
    end

    assign collision_set = out_valid_q & out_bird_q & out_obstacle_q;

    // Bird position latch; a pixel in the frame_start cycle still sees the old one
    always_ff @(posedge clk) begin
        if (rst) begin
            bx_q <= '0;
            by_q <= '0;
        end else if (frame_start) begin
            bx_q <= bird_x;
            by_q <= bird_y;
        end
    end

    // Stage 1: register box hit, ROM address, valid and (qualified) obstacle
    always_ff @(posedge clk) begin
        if (rst) begin
            in_box_q <= 1'b0;
            rom_ad_q <= 8'd0;
            valid1_q <= 1'b0;
            obs1_q   <= 1'b0;
        end else begin
            in_box_q <= in_box_d;
            rom_ad_q <= rom_ad_d;
            valid1_q <= pix_valid;
            obs1_q   <= pix_valid & obstacle_px;
        end
    end

    // Stage 2: combine the ROM bit with the box hit and align the obstacle
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_bird_q     <= 1'b0;
            out_obstacle_q <= 1'b0;
        end else begin
            out_valid_q    <= valid1_q;
            out_bird_q     <= in_box_q & rom_dout;
            out_obstacle_q <= obs1_q;
        end
    end

    // Sticky per-frame collision flag, handed over to frame_collision at frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            collision_live_q  <= 1'b0;
            frame_collision_q <= 1'b0;
        end else if (frame_start) begin
            frame_collision_q <= collision_live_q | collision_set;
            collision_live_q  <= 1'b0;
        end else if (collision_set) begin
            collision_live_q  <= 1'b1;
        end
    end

    assign rom_ad          = rom_ad_q;
    assign out_valid       = out_valid_q;
    assign out_bird        = out_bird_q;
    assign out_obstacle    = out_obstacle_q;
    assign frame_collision = frame_collision_q;

endmodule

// File: tb/tb_bird_sprite_renderer.sv
// Testbench for bird_sprite_renderer: directed scenarios plus randomized rasters,
// each cycle checked against a pixel-level reference model.
module tb_bird_sprite_renderer;

    logic       clk = 1'b0;
    logic       rst, frame_start, pix_valid, obstacle_px, rom_dout;
    logic [9:0] bird_x, bird_y, pix_x, pix_y;
    logic [7:0] rom_ad;
    logic       out_valid, out_bird, out_obstacle, frame_collision;

    int tests = 0;
    int fails = 0;

    // Behavioural bird image
    logic mem [256];
    assign rom_dout = mem[rom_ad];

    always #5 clk = ~clk;

    bird_sprite_renderer #(.SPRITE_W(16), .SPRITE_H(13), .COORD_W(10)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .bird_x(bird_x), .bird_y(bird_y),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .obstacle_px(obstacle_px),
        .rom_ad(rom_ad), .rom_dout(rom_dout),
        .out_valid(out_valid), .out_bird(out_bird), .out_obstacle(out_obstacle),
        .frame_collision(frame_collision)
    );

    // Reference model: bird position, what the pixel sampled last cycle should
    // have produced (address / in-box), what the pixel two cycles back should
    // show on the outputs, and the frame collision bookkeeping.
    int mbx, mby;
    bit p1v, p1in, p1obs;
    int p1a;
    bit p2v, p2b, p2o;
    bit live, fc;

    function automatic bit inside_box(int x, int y);
        return (x >= mbx) && (x < mbx + 16) && (y >= mby) && (y < mby + 13);
    endfunction

    function automatic bit opaque_at(int x, int y);
        if (!inside_box(x, y)) return 1'b0;
        return mem[((y - mby) * 16 + (x - mbx)) % 256];
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check at the negedge
    task automatic step(input bit r, input bit fs, input int nbx, input int nby,
                        input bit pv, input int px, input int py, input bit obs);
        bit set, ins;
        rst = r; frame_start = fs;
        bird_x = 10'(nbx); bird_y = 10'(nby);
        pix_valid = pv; pix_x = 10'(px); pix_y = 10'(py); obstacle_px = obs;
        @(posedge clk);
        if (r) begin
            mbx = 0; mby = 0;
            p1v = 0; p1in = 0; p1obs = 0; p1a = 0;
            p2v = 0; p2b = 0; p2o = 0; live = 0; fc = 0;
        end else begin
            set = p2v && p2b && p2o;
            if (fs) begin fc = live || set; live = 0; end
            else if (set) live = 1;
            p2v = p1v; p2b = p1in && mem[p1a]; p2o = p1obs;
            ins   = pv && inside_box(px, py);
            p1v   = pv;
            p1in  = ins;
            p1obs = pv && obs;
            p1a   = ins ? ((py - mby) * 16 + (px - mbx)) % 256 : 0;
            if (fs) begin mbx = nbx; mby = nby; end
        end
        @(negedge clk);
        chk("rom_ad", 32'(rom_ad), 32'(p1a));
        chk("out_valid", 32'(out_valid), 32'(p2v));
        chk("out_bird", 32'(out_bird), 32'(p2b));
        chk("out_obstacle", 32'(out_obstacle), 32'(p2o));
        chk("frame_collision", 32'(frame_collision), 32'(fc));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Raster a window; mode 0: random obstacles, 1: obstacles on opaque bird
    // pixels, 2: obstacles only where the bird is transparent or absent.
    task automatic raster(int x0, int x1, int y0, int y1, int mode);
        bit pv, obs, op;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                pv = ($urandom_range(0, 9) != 0);
                op = opaque_at(x, y);
                case (mode)
                    1:       obs = op;
                    2:       obs = op ? 1'b0 : 1'($urandom_range(0, 1));
                    default: obs = 1'($urandom_range(0, 1));
                endcase
                step(0, 0, 0, 0, pv, x, y, obs);
            end
        end
        idle(); idle();
        $display("[TB] raster x%0d..%0d y%0d..%0d mode %0d done", x0, x1, y0, y1, mode);
    endtask

    initial begin
        int rbx, rby;
        for (int i = 0; i < 256; i++) mem[i] = 1'($urandom_range(0, 1));
        mem[0] = 1'b1;   // an address-0 leak would show up as an opaque pixel

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 5, 1, 5, 5, 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_rom_ad", 32'(rom_ad), 0);
        $display("[TB] reset released");

        // Pixel in the frame_start cycle uses the old (0,0) position
        step(0, 1, 100, 50, 1, 3, 2, 0);
        chk("fs_old_pos_rom_ad", 32'(rom_ad), 35);
        // Bird (100,50), pixel (105,52) -> address 37
        step(0, 0, 0, 0, 1, 105, 52, 0);
        chk("s31_rom_ad", 32'(rom_ad), 37);
        idle();
        chk("s31_out_valid", 32'(out_valid), 1);
        chk("s31_out_bird", 32'(out_bird), 32'(mem[37]));
        $display("[TB] pixel (105,52) rom_ad 37 bird %0d", out_bird);

        // Just outside the box on right, left and bottom
        step(0, 0, 0, 0, 1, 116, 50, 0); chk("s32_r_rom_ad", 32'(rom_ad), 0);
        idle(); chk("s32_r_valid", 32'(out_valid), 1); chk("s32_r_bird", 32'(out_bird), 0);
        step(0, 0, 0, 0, 1, 99, 50, 0);  chk("s32_l_rom_ad", 32'(rom_ad), 0);
        idle(); chk("s32_l_valid", 32'(out_valid), 1); chk("s32_l_bird", 32'(out_bird), 0);
        step(0, 0, 0, 0, 1, 100, 63, 0); chk("s32_b_rom_ad", 32'(rom_ad), 0);
        idle(); chk("s32_b_valid", 32'(out_valid), 1); chk("s32_b_bird", 32'(out_bird), 0);
        $display("[TB] out-of-box pixels checked");

        // Right-edge clipping: no wrap to column 0
        step(0, 1, 1020, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1023, 0, 0); chk("s33_rom_ad", 32'(rom_ad), 3);
        step(0, 0, 0, 0, 1, 0, 0, 0);    chk("s33_wrap_rom_ad", 32'(rom_ad), 0);
        chk("s33_edge_bird", 32'(out_bird), 32'(mem[3]));
        idle(); chk("s33_wrap_valid", 32'(out_valid), 1); chk("s33_wrap_bird", 32'(out_bird), 0);
        raster(1010, 1023, 0, 14, 0);
        $display("[TB] edge clipping checked");

        // Overlap frame, then a clean frame
        step(0, 1, 100, 50, 0, 0, 0, 0);
        raster(95, 120, 46, 66, 1);
        step(0, 1, 100, 50, 0, 0, 0, 0);
        chk("s34_collision", 32'(frame_collision), 1);
        raster(95, 120, 46, 66, 2);
        step(0, 1, 300, 200, 0, 0, 0, 0);
        chk("s34_no_collision", 32'(frame_collision), 0);
        $display("[TB] frame collision %0d after clean frame", frame_collision);

        // Randomized frames
        for (int f = 0; f < 3; f++) begin
            rbx = (f == 2) ? $urandom_range(1008, 1023) : $urandom_range(0, 1000);
            rby = $urandom_range(0, 760);
            step(0, 1, rbx, rby, 1, $urandom_range(0, 1023), $urandom_range(0, 767), 1);
            raster((rbx > 3) ? rbx - 3 : 0, (rbx + 18 > 1023) ? 1023 : rbx + 18,
                   (rby > 2) ? rby - 2 : 0, rby + 15, 0);
        end

        // Reset mid-raster with two pixels in flight after a colliding frame
        step(0, 1, 200, 100, 0, 0, 0, 0);
        raster(200, 215, 100, 112, 1);
        step(0, 1, 200, 100, 1, 201, 101, 1);
        chk("s35_pre_collision", 32'(frame_collision), 1);
        step(0, 0, 0, 0, 1, 202, 101, 1);
        step(0, 0, 0, 0, 1, 203, 101, 1);
        step(1, 1, 7, 7, 1, 204, 101, 1);
        chk("s35_valid", 32'(out_valid), 0);
        chk("s35_bird", 32'(out_bird), 0);
        chk("s35_obstacle", 32'(out_obstacle), 0);
        chk("s35_rom_ad", 32'(rom_ad), 0);
        chk("s35_collision", 32'(frame_collision), 0);
        idle(); chk("s35_flush1", 32'(out_valid), 0);
        idle(); chk("s35_flush2", 32'(out_valid), 0);
        $display("[TB] reset mid-raster checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bird_sprite_renderer.md
BIRD_SPRITE_RENDERER -- requirements
Module: bird_sprite_renderer

Interface
REQ-001 Parameter SPRITE_W, default 16, sprite width in pixels; ROM row stride.
REQ-002 Parameter SPRITE_H, default 13, sprite height in rows (SPRITE_W*SPRITE_H = 208 ROM bits used).
REQ-003 Parameter COORD_W, default 10, screen coordinate width.
REQ-004 clk  input  1  single clock; all state is updated on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 frame_start  input  1  one-cycle pulse at frame start; latches bird position.
REQ-007 bird_x  input  COORD_W  sprite top-left column, sampled only on frame_start.
REQ-008 bird_y  input  COORD_W  sprite top-left row, sampled only on frame_start.
REQ-009 pix_valid  input  1  qualifies pix_x, pix_y and obstacle_px this cycle.
REQ-010 pix_x, pix_y  input  COORD_W each  coordinate of the pixel being rendered.
REQ-011 obstacle_px  input  1  obstacle pixel present at (pix_x, pix_y).
REQ-012 rom_ad  output  8  registered bird image ROM address.
REQ-013 rom_dout  input  1  combinational ROM data for rom_ad, valid in the same cycle.
REQ-014 out_valid  output  1  pixel result valid.
REQ-015 out_bird  output  1  bird pixel opaque at the pixel result.
REQ-016 out_obstacle  output  1  obstacle_px delayed to align with out_bird.
REQ-017 frame_collision  output  1  previous frame contained a bird/obstacle overlap.

Function
REQ-018 Stored position bx/by SHALL load from bird_x/bird_y on frame_start; a pixel sampled in the same cycle as frame_start SHALL use the old position.
REQ-019 Stage 1 (cycle N+1 for a pixel sampled at cycle N): register in_box = pix_valid & (bx <= pix_x < bx+SPRITE_W) & (by <= pix_y < by+SPRITE_H), evaluated at COORD_W+1 bits so that bx+SPRITE_W never wraps.
REQ-020 Stage 1 SHALL register rom_ad = (pix_y-by)*SPRITE_W + (pix_x-bx), truncated to 8 bits, when in_box; otherwise rom_ad SHALL be 0.
REQ-021 Stage 1 SHALL register valid1 = pix_valid and obs1 = obstacle_px.
REQ-022 Stage 2 (cycle N+2): out_valid = valid1, out_bird = in_box & rom_dout, out_obstacle = obs1; fixed latency 2 cycles, back-to-back pixels are accepted every cycle, no stall.
REQ-023 When pix_valid=0, the pipeline SHALL carry out_valid=0, out_bird=0 and out_obstacle=0 for that slot.
REQ-024 Sticky collision_live SHALL set when out_valid & out_bird & out_obstacle.
REQ-025 On frame_start, frame_collision SHALL load collision_live OR a set condition in the same cycle, and collision_live SHALL clear; results emerging after frame_start count toward the new frame.
REQ-026 frame_collision SHALL hold its value between frame_start pulses.
REQ-027 Coordinates at the screen edge (bx+SPRITE_W > 2^COORD_W-1) SHALL clip; pixels beyond the max coordinate SHALL NOT wrap to column 0.

Reset
REQ-028 rst SHALL force bx, by, rom_ad, in_box, valid1, obs1, out_valid, out_bird, out_obstacle, collision_live and frame_collision to 0 in the next cycle.
REQ-029 rst SHALL take priority over frame_start and pix_valid; pixels in flight at reset SHALL be discarded (no out_valid).

Verification
REQ-030 Bench drives rom_dout from a 256x1 behavioural model of the bird ROM image; scoreboard compares every out_valid against mem[(y-by)*16+(x-bx)].
REQ-031 Scenario: frame_start with bird (100,50), pixel (105,52) at cycle N -> rom_ad=37 at N+1, out_valid=1 and out_bird=mem[37] at N+2.
REQ-032 Scenario: pixels (116,50), (99,50), (100,63) -> rom_ad=0, out_bird=0, out_valid=1 for each.
REQ-033 Scenario: bird (1020,0), pixel (1023,0) -> rom_ad=3; pixel (0,0) -> out_bird=0 (no wrap).
REQ-034 Scenario: full-frame raster with obstacle_px=1 over opaque bird pixels -> next frame_start gives frame_collision=1; a following frame without overlap -> frame_collision=0.
REQ-035 Scenario: rst asserted mid-raster with 2 pixels in flight -> all outputs 0 next cycle, no out_valid for those pixels, frame_collision=0.
